stack_push_pop_sequencer: RTL

- Multi-cycle controller that sequences CALL/INT pushes and RET/RTI pops of the 32-bit PC (pc_h:pc_l) and 4-bit flags through the memory-data forwarding path.
- Owns the stack pointer and drives the PC/flags selector and push-select lines of the PC forwarding mux.
- Issues memory read/write strobes and stalls the pipeline until the sequence completes.

---
 rtl/stack_push_pop_sequencer_pkg.sv | 46 ++++
 rtl/stack_push_pop_sequencer_if.sv | 50 +++++
 rtl/stack_push_pop_sequencer_stack_pointer_unit.sv | 37 +++
 rtl/stack_push_pop_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_push_pop_sequencer_pkg.sv
// Shared types and defaults for the stack push/pop sequencer.
// STACK_GUARD_EN enables stack overflow/underflow suppression.
package stack_push_pop_sequencer_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam logic [15:0] SP_RESET_DEF = 16'hFFFF;
  localparam logic [15:0] SP_LIMIT_DEF = 16'hF000;

`ifdef STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE,
    PUSH_L,
    PUSH_H,
    PUSH_F,
    POP_F,
    POP_H,
    POP_L,
    WAIT_L,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_INT,
    OP_CALL,
    OP_RTI,
    OP_RET
  } op_t;

  // int > call > rti > ret; the caller guarantees one is high
  function automatic op_t pick_op(
    input logic i_int,
    input logic i_call,
    input logic i_rti
  );
    if (i_int) return OP_INT;
    if (i_call) return OP_CALL;
    if (i_rti) return OP_RTI;
    return OP_RET;
  endfunction

endpackage

// File: rtl/stack_push_pop_sequencer_if.sv
// Request, forwarding-mux and stack memory bundle of the sequencer.
// master = pipeline/memory side, slave = sequencer.
interface stack_push_pop_sequencer_if
  import stack_push_pop_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              int_req;
  logic              call_req;
  logic              rti_req;
  logic              ret_req;
  logic [15:0]       pc_l;
  logic [15:0]       pc_h;
  logic [15:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic              half_pc_sel;
  logic              flags_sel;
  logic              push_pc_flags;
  logic              stall;
  logic              pc_load;
  logic [31:0]       pc_value;
  logic              flags_load;
  logic [3:0]        flags_value;
  logic              done;
  logic              stack_err;

  modport master (
    output int_req, call_req, rti_req, ret_req,
    output pc_l, pc_h, mem_rdata,
    input  mem_addr, mem_we, mem_re,
    input  half_pc_sel, flags_sel, push_pc_flags,
    input  stall, pc_load, pc_value,
    input  flags_load, flags_value,
    input  done, stack_err
  );

  modport slave (
    input  int_req, call_req, rti_req, ret_req,
    input  pc_l, pc_h, mem_rdata,
    output mem_addr, mem_we, mem_re,
    output half_pc_sel, flags_sel, push_pc_flags,
    output stall, pc_load, pc_value,
    output flags_load, flags_value,
    output done, stack_err
  );

endinterface

// File: rtl/stack_push_pop_sequencer_stack_pointer_unit.sv
// Stack pointer register with inc/dec and the optional guard compares.
module stack_push_pop_sequencer_stack_pointer_unit
  import stack_push_pop_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEF),
  parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [ADDR_W-1:0] o_sp,
  output logic [ADDR_W-1:0] o_sp_inc,
  output logic              o_push_blk,
  output logic              o_pop_blk
);

  logic [ADDR_W-1:0] r_sp;

  // modulo 2^ADDR_W arithmetic: wrap is natural
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= SP_RESET;
    end else if (i_dec) begin
      r_sp <= r_sp - ADDR_W'(1);
    end else if (i_inc) begin
      r_sp <= r_sp + ADDR_W'(1);
    end
  end

  assign o_sp       = r_sp;
  assign o_sp_inc   = r_sp + ADDR_W'(1);
  assign o_push_blk = GUARD_EN && (r_sp < SP_LIMIT);
  assign o_pop_blk  = GUARD_EN && (r_sp == SP_RESET);

endmodule

// File: rtl/stack_push_pop_sequencer.sv
// CALL/INT push and RET/RTI pop sequencer for PC and flags.
// STACK_GUARD_EN adds sticky stack_err and suppressed accesses.
module stack_push_pop_sequencer
  import stack_push_pop_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEF),
  parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEF)
) (
  input logic                       clk,
  input logic                       rst_n,
  stack_push_pop_sequencer_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  op_t               r_op;
  op_t               w_op;
  logic              w_any_req;
  logic [ADDR_W-1:0] w_sp;
  logic [ADDR_W-1:0] w_sp_inc;
  logic              w_push_blk;
  logic              w_pop_blk;
  logic              w_is_push;
  logic              w_is_pop;

  logic              w_we;
  logic              w_re;
  logic              w_half;
  logic              w_fsel;
  logic              w_push;
  logic              w_inc;
  logic              w_dec;
  logic              w_pc_load;
  logic              w_flags_load;
  logic              w_done;
  logic [ADDR_W-1:0] w_addr;

  logic [15:0]       r_pc_h;
  logic [31:0]       r_pc_value;
  logic [3:0]        r_flags_value;

  stack_push_pop_sequencer_stack_pointer_unit #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET),
    .SP_LIMIT (SP_LIMIT)
  ) u_spu (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_inc),
    .i_dec      (w_dec),
    .o_sp       (w_sp),
    .o_sp_inc   (w_sp_inc),
    .o_push_blk (w_push_blk),
    .o_pop_blk  (w_pop_blk)
  );

  // reset also masks acceptance so stall is 0 while rst_n is low
  assign w_any_req = rst_n & (bus.int_req | bus.call_req |
                              bus.rti_req | bus.ret_req);
  assign w_op = pick_op(bus.int_req, bus.call_req, bus.rti_req);

  assign w_is_push = (r_state == PUSH_L) || (r_state == PUSH_H) ||
                     (r_state == PUSH_F);
  assign w_is_pop  = (r_state == POP_F) || (r_state == POP_H) ||
                     (r_state == POP_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_INT;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any_req) begin
        r_op <= w_op;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          unique case (w_op)
            OP_INT, OP_CALL: w_next = PUSH_L;
            OP_RTI:          w_next = POP_F;
            default:         w_next = POP_H;
          endcase
        end
      end
      PUSH_L: w_next = w_push_blk ? DONE : PUSH_H;
      PUSH_H: begin
        if (w_push_blk || r_op != OP_INT) begin
          w_next = DONE;
        end else begin
          w_next = PUSH_F;
        end
      end
      PUSH_F: w_next = DONE;
      POP_F:  w_next = w_pop_blk ? DONE : POP_H;
      POP_H:  w_next = w_pop_blk ? DONE : POP_L;
      POP_L:  w_next = w_pop_blk ? DONE : WAIT_L;
      WAIT_L: w_next = IDLE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_we         = 1'b0;
    w_re         = 1'b0;
    w_half       = 1'b0;
    w_fsel       = 1'b0;
    w_push       = 1'b0;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    w_pc_load    = 1'b0;
    w_flags_load = 1'b0;
    w_done       = 1'b0;
    w_addr       = w_sp;
    unique case (r_state)
      PUSH_L, PUSH_H, PUSH_F: begin
        w_we   = !w_push_blk;
        w_push = !w_push_blk;
        w_dec  = !w_push_blk;
        w_half = !w_push_blk && (r_state == PUSH_H);
        w_fsel = !w_push_blk && (r_state == PUSH_F);
      end
      POP_F, POP_H, POP_L: begin
        w_re   = !w_pop_blk;
        w_inc  = !w_pop_blk;
        w_addr = w_sp_inc;
        // POP_H sees the word read in POP_F: the flags
        w_flags_load = !w_pop_blk && (r_state == POP_H) &&
                       (r_op == OP_RTI);
      end
      WAIT_L: begin
        w_pc_load = 1'b1;
        w_done    = 1'b1;
      end
      DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_h        <= '0;
      r_pc_value    <= '0;
      r_flags_value <= '0;
    end else begin
      if (r_state == POP_L) begin
        r_pc_h <= bus.mem_rdata;
      end
      if (w_pc_load) begin
        r_pc_value <= {r_pc_h, bus.mem_rdata};
      end
      if (w_flags_load) begin
        r_flags_value <= bus.mem_rdata[3:0];
      end
    end
  end

`ifdef STACK_GUARD_EN
  logic r_err;
  logic w_err_set;

  assign w_err_set = (w_is_push && w_push_blk) ||
                     (w_is_pop && w_pop_blk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign bus.stack_err = r_err;
`else
  assign bus.stack_err = 1'b0;
`endif

  assign bus.mem_addr      = w_addr;
  assign bus.mem_we        = w_we;
  assign bus.mem_re        = w_re;
  assign bus.half_pc_sel   = w_half;
  assign bus.flags_sel     = w_fsel;
  assign bus.push_pc_flags = w_push;
  assign bus.stall         = (r_state != IDLE) || w_any_req;
  assign bus.pc_load       = w_pc_load;
  assign bus.pc_value      = w_pc_load ?
                             {r_pc_h, bus.mem_rdata} : r_pc_value;
  assign bus.flags_load    = w_flags_load;
  assign bus.flags_value   = w_flags_load ?
                             bus.mem_rdata[3:0] : r_flags_value;
  assign bus.done          = w_done;

endmodule
